// File: rtl/uart_dev_if.sv
// uart_dev_if: cpu byte-bus handshake bundle between the cpu (master) and
// the uart_dev slave.
//   valid/write/addr/wdata : request from the cpu
//   rdata/ready            : registered response from the slave
//   sel                    : combinational address decode from the slave
interface uart_dev_if;
  logic        valid;
  logic        write;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        sel;

  modport master (output valid, write, addr, wdata, input rdata, ready, sel);
  modport slave  (input valid, write, addr, wdata, output rdata, ready, sel);
endinterface

// File: rtl/uart_dev.sv
// uart_dev: memory-mapped 8N1 UART slave on the cpu byte bus.
//   Registers at BASE+0 DATA, +1 STATUS, +2 DIV_LO, +3 DIV_HI.
//   DATA writes feed a TX FIFO drained by a bit serialiser onto tx.
//   Optional receiver (macro UART_DEV_RX_EN) deserialises rx into a
//   one-byte holding register read back through DATA.
// Ports:
//   clk   : clock, all state on posedge
//   rstb  : asynchronous active-low reset
//   bus   : uart_dev_if.slave (valid/write/addr/wdata in, rdata/ready/sel out)
//   tx    : serial out, idle high (registered)
//   rx    : serial in, asynchronous to clk (ignored without UART_DEV_RX_EN)
module uart_dev #(
  parameter logic [15:0] BASE     = 16'h1100,
  parameter int unsigned TX_DEPTH = 4,
  parameter logic [15:0] DIV_RST  = 16'd433
) (
  input  logic      clk,
  input  logic      rstb,
  uart_dev_if.slave bus,
  output logic      tx,
  input  logic      rx
);
  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [15:0]      off;
  logic             fire, wr_data, wr_lo, wr_hi, rd_status;
  logic             ready_q;
  logic [7:0]       rdata_q, rd_mux, status;
  logic [15:0]      div;
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr, occ;
  logic             tx_full, tx_empty, push, pop, tx_overflow, tx_busy;
  tx_state_t        tx_state;
  logic [15:0]      tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;
  logic             tx_q;
  logic             rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]       rx_hold;

  // Address decode and single-shot access strobes
  assign off       = bus.addr - BASE;
  assign bus.sel   = (off[15:2] == 14'd0);
  assign fire      = bus.valid & bus.sel & ~ready_q;
  assign wr_data   = fire &  bus.write & (off[1:0] == 2'd0);
  assign wr_lo     = fire &  bus.write & (off[1:0] == 2'd2);
  assign wr_hi     = fire &  bus.write & (off[1:0] == 2'd3);
  assign rd_status = fire & ~bus.write & (off[1:0] == 2'd1);

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign tx        = tx_q;

  // FIFO occupancy from wrapping pointers with one extra bit
  assign occ      = wr_ptr - rd_ptr;
  assign tx_full  = (occ == CNT_W'(TX_DEPTH));
  assign tx_empty = (occ == CNT_W'(0));
  assign push     = wr_data & ~tx_full;
  assign pop      = ~tx_empty & ((tx_state == TX_IDLE) |
                    ((tx_state == TX_STOP) & (tx_cnt == 16'd0)));
  assign tx_busy  = (tx_state != TX_IDLE);

  assign status = {1'b0, rx_frame_err, tx_overflow, tx_busy,
                   rx_overrun, rx_valid, tx_empty, tx_full};

  // Read data mux
  always_comb begin
    rd_mux = 8'h00;
    case (off[1:0])
      2'd0:    rd_mux = rx_hold;
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = div[7:0];
      default: rd_mux = div[15:8];
    endcase
  end

  // Bus handshake, divisor and TX overflow flag
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_q     <= 1'b0;
      rdata_q     <= 8'h00;
      div         <= DIV_RST;
      tx_overflow <= 1'b0;
    end else begin
      if (fire)            ready_q <= 1'b1;
      else if (!bus.valid) ready_q <= 1'b0;
      if (fire && !bus.write) rdata_q <= rd_mux;
      if (wr_lo) div[7:0]  <= bus.wdata;
      if (wr_hi) div[15:8] <= bus.wdata;
      if (rd_status)           tx_overflow <= 1'b0;
      if (wr_data && tx_full)  tx_overflow <= 1'b1;
    end
  end

  // FIFO storage (no reset needed, gated by pointers)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + CNT_W'(push);
      rd_ptr <= rd_ptr + CNT_W'(pop);
    end
  end

  // TX serialiser; tx is registered from state, so the line lags state by one clock
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= (tx_state == TX_START) ? 1'b0 :
              (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;
      if (tx_state == TX_IDLE) begin
        if (pop) begin
          tx_state <= TX_START;
          tx_sh    <= fifo_mem[rd_ptr[PTR_W-1:0]];
          tx_cnt   <= div;
        end
      end else if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        // Bit boundary: reload picks up any new divisor here
        tx_cnt <= div;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= 3'd0;
          end
          TX_DATA: begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (pop) begin
              tx_state <= TX_START;
              tx_sh    <= fifo_mem[rd_ptr[PTR_W-1:0]];
            end else begin
              tx_state <= TX_IDLE;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

`ifdef UART_DEV_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state;
  logic [2:0]  rx_sync;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [16:0] rx_half;
  logic        rd_data, rx_s, rx_fall, stop_smp, rx_good, rx_load;

  // rx_sync[1:0] is the synchroniser, rx_sync[2] the previous sample for edge detect
  assign rd_data  = fire & ~bus.write & (off[1:0] == 2'd0);
  assign rx_s     = rx_sync[1];
  assign rx_fall  = rx_sync[2] & ~rx_sync[1];
  assign rx_half  = (17'(div) + 17'd1) >> 1;
  assign stop_smp = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
  assign rx_good  = stop_smp & rx_s;
  // A DATA read on the same edge frees the holding register; the load wins
  assign rx_load  = rx_good & (~rx_valid | rd_data);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_sync      <= 3'b111;
      rx_state     <= RX_IDLE;
      rx_cnt       <= 16'd0;
      rx_bit       <= 3'd0;
      rx_sh        <= 8'h00;
      rx_hold      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], rx};
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= (rx_half == 17'd0) ? 16'd0 : 16'(rx_half - 17'd1);
          end
        end
        RX_START: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else if (rx_s)       rx_state <= RX_IDLE;
          else begin
            rx_state <= RX_DATA;
            rx_cnt   <= div;
            rx_bit   <= 3'd0;
          end
        end
        RX_DATA: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            rx_cnt <= div;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else                 rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
      if (rd_data) rx_valid <= 1'b0;
      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_hold  <= rx_sh;
      end
      if (rd_status) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      if (rx_good & ~rx_load) rx_overrun   <= 1'b1;
      if (stop_smp & ~rx_s)   rx_frame_err <= 1'b1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx    = rx;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_hold      = 8'h00;
`endif

endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev: self-checking bench for uart_dev (register table, TX frame
// scoreboard, FIFO overflow, async reset, and receiver when UART_DEV_RX_EN).
module tb_uart_dev;
  localparam logic [15:0] BASE = 16'h1100;
`ifdef UART_DEV_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp;
    bit          sel;
  } vec_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  logic rx   = 1'b1;
  logic tx;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int mon_div = 3;
  bit mon_off = 1'b0;
  int last_fire = 0;

  logic [7:0] tx_exp [$];
  logic [7:0] rd_exp [$];
  int         start_q [$];
  vec_t       vecs [15];

  uart_dev_if bus ();

  uart_dev #(.BASE(BASE), .TX_DEPTH(4), .DIV_RST(16'd433)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full bus access; read expectations go through the rd_exp scoreboard
  task automatic bus_acc(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] exp, input bit exp_tx, input string nm);
    bit got = 1'b0;
    logic [7:0] e;
    if (wr && exp_tx) tx_exp.push_back(wd);
    if (!wr) rd_exp.push_back(exp);
    bus.valid = 1'b1; bus.write = wr; bus.addr = a; bus.wdata = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s ready: got 0 expected 1", nm);
      if (!wr) void'(rd_exp.pop_front());
    end else begin
      last_fire = cyc;
      if (!wr) begin
        e = rd_exp.pop_front();
        check({nm, " rdata"}, 32'(bus.rdata), 32'(e));
      end
      @(posedge clk); #1;
      check({nm, " ready hold"}, 32'(bus.ready), 32'h1);
    end
    bus.valid = 1'b0;
    @(posedge clk); #1;
    check({nm, " ready drop"}, 32'(bus.ready), 32'h0);
  endtask

  task automatic bus_nosel(input bit wr, input logic [15:0] a, input string nm);
    bus.valid = 1'b1; bus.write = wr; bus.addr = a; bus.wdata = 8'h5A;
    @(posedge clk); #1;
    check({nm, " sel"}, 32'(bus.sel), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check({nm, " ready"}, 32'(bus.ready), 32'h0);
    bus.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int per);
    rx = 1'b0;
    repeat (per) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(posedge clk);
    end
    rx = stop;
    repeat (per) @(posedge clk);
    rx = 1'b1;
  endtask

  // TX line monitor: decodes frames mid-bit and pops the tx_exp scoreboard
  initial begin : tx_mon
    logic       prev;
    logic [7:0] sh;
    logic [7:0] e;
    int         cnt;
    int         ph;
    bit         act;
    prev = 1'b1; sh = 8'h00; cnt = 0; ph = 0; act = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rstb || mon_off) begin
        act = 1'b0;
      end else if (!act) begin
        if (prev && !tx) begin
          act = 1'b1; ph = 0; cnt = (mon_div + 1) / 2;
          start_q.push_back(cyc);
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          cnt = mon_div + 1;
          if (ph == 0) begin
            check("tx start bit", 32'(tx), 32'h0);
          end else if (ph <= 8) begin
            sh = {tx, sh[7:1]};
          end else begin
            act = 1'b0;
            check("tx stop bit", 32'(tx), 32'h1);
            if (tx_exp.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL tx frame: got %0h expected none", sh);
            end else begin
              e = tx_exp.pop_front();
              check("tx frame byte", 32'(sh), 32'(e));
            end
          end
          ph++;
        end
      end
      prev = tx;
    end
  end

  initial begin : main
    logic [7:0] bytes5 [5];
    logic       wave;
    int         a5_fire;

    bus.valid = 1'b0; bus.write = 1'b0; bus.addr = 16'h0000; bus.wdata = 8'h00;

    vecs[0]  = '{1'b0, 16'h1101, 8'h00, 8'h02, 1'b1};
    vecs[1]  = '{1'b0, 16'h1102, 8'h00, 8'hB1, 1'b1};
    vecs[2]  = '{1'b0, 16'h1103, 8'h00, 8'h01, 1'b1};
    vecs[3]  = '{1'b0, 16'h1100, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 16'h1102, 8'h11, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 16'h1103, 8'h22, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 16'h1102, 8'h00, 8'h11, 1'b1};
    vecs[7]  = '{1'b0, 16'h1103, 8'h00, 8'h22, 1'b1};
    vecs[8]  = '{1'b1, 16'h1103, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 16'h1102, 8'h03, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 16'h1102, 8'h00, 8'h03, 1'b1};
    vecs[11] = '{1'b0, 16'h1103, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{1'b0, 16'h1104, 8'h00, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 16'h10FF, 8'h00, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 16'h1101, 8'h00, 8'h02, 1'b1};

    bytes5[0] = 8'h01; bytes5[1] = 8'h80; bytes5[2] = 8'h5A;
    bytes5[3] = 8'hC3; bytes5[4] = 8'hFF;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst tx", 32'(tx), 32'h1);
    check("rst ready", 32'(bus.ready), 32'h0);
    check("rst rdata", 32'(bus.rdata), 32'h0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Register table; leaves DIV = 3
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].sel)
        bus_acc(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
      else
        bus_nosel(vecs[i].wr, vecs[i].addr, $sformatf("vec%0d", i));
    end
    mon_div = 3;

    // Single frame 0xA5, exact waveform plus busy status mid-frame
    start_q.delete();
    bus_acc(1'b1, 16'h1100, 8'hA5, 8'h00, 1'b1, "wr A5");
    a5_fire = last_fire;
    while (cyc < a5_fire + 2) begin
      @(posedge clk); #1;
    end
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          if (c > 0) begin
            @(posedge clk); #1;
          end
          if (c < 4)       wave = 1'b0;
          else if (c < 36) wave = (((8'hA5 >> ((c - 4) / 4)) & 8'h01) != 8'h00);
          else             wave = 1'b1;
          check($sformatf("A5 wave c%0d", c), 32'(tx), 32'(wave));
        end
      end
      bus_acc(1'b0, 16'h1101, 8'h00, 8'h12, 1'b0, "A5 busy status");
    join
    repeat (6) @(posedge clk);
    #1;
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h02, 1'b0, "A5 idle status");
    check("A5 frame count", 32'(start_q.size()), 32'h1);
    if (start_q.size() > 0) check("A5 start latency", 32'(start_q[0] - a5_fire), 32'h2);

    // Five back-to-back bytes, no idle gap
    start_q.delete();
    for (int i = 0; i < 5; i++) bus_acc(1'b1, 16'h1100, bytes5[i], 8'h00, 1'b1, $sformatf("wr b%0d", i));
    repeat (230) @(posedge clk);
    #1;
    check("b2b frame count", 32'(start_q.size()), 32'h5);
    if (start_q.size() == 5)
      for (int i = 1; i < 5; i++)
        check($sformatf("b2b spacing %0d", i), 32'(start_q[i] - start_q[i-1]), 32'd40);

    // Stalled TX: fill FIFO, overflow, then async reset mid-frame
    mon_off = 1'b1;
    bus_acc(1'b1, 16'h1102, 8'hFF, 8'h00, 1'b0, "div lo FF");
    bus_acc(1'b1, 16'h1103, 8'hFF, 8'h00, 1'b0, "div hi FF");
    for (int i = 0; i < 6; i++) bus_acc(1'b1, 16'h1100, 8'h00, 8'h00, 1'b0, $sformatf("fill%0d", i));
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h31, 1'b0, "ovf status");
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h11, 1'b0, "ovf status clr");
    check("stall tx low", 32'(tx), 32'h0);
    #2 rstb = 1'b0;
    #1;
    check("async rst tx", 32'(tx), 32'h1);
    check("async rst ready", 32'(bus.ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    mon_off = 1'b0;
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h02, 1'b0, "post rst status");
    bus_acc(1'b0, 16'h1102, 8'h00, 8'hB1, 1'b0, "post rst div lo");

    // Receiver at DIV = 7
    bus_acc(1'b1, 16'h1102, 8'h07, 8'h00, 1'b0, "div lo 07");
    bus_acc(1'b1, 16'h1103, 8'h00, 8'h00, 1'b0, "div hi 00");
    mon_div = 7;
    send_rx(8'h3C, 1'b1, 8);
    repeat (16) @(posedge clk);
    #1;
    bus_acc(1'b0, 16'h1101, 8'h00, RX_EN ? 8'h06 : 8'h02, 1'b0, "rx1 status");
    bus_acc(1'b0, 16'h1100, 8'h00, RX_EN ? 8'h3C : 8'h00, 1'b0, "rx1 data");
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h02, 1'b0, "rx1 status clr");

    send_rx(8'h11, 1'b1, 8);
    send_rx(8'h22, 1'b1, 8);
    repeat (16) @(posedge clk);
    #1;
    bus_acc(1'b0, 16'h1101, 8'h00, RX_EN ? 8'h0E : 8'h02, 1'b0, "ovr status");
    bus_acc(1'b0, 16'h1100, 8'h00, RX_EN ? 8'h11 : 8'h00, 1'b0, "ovr data");
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h02, 1'b0, "ovr status clr");

    send_rx(8'h33, 1'b0, 8);
    repeat (16) @(posedge clk);
    #1;
    bus_acc(1'b0, 16'h1101, 8'h00, RX_EN ? 8'h42 : 8'h02, 1'b0, "ferr status");
    bus_acc(1'b0, 16'h1100, 8'h00, RX_EN ? 8'h11 : 8'h00, 1'b0, "ferr hold");
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h02, 1'b0, "ferr status clr");

    // Short low glitch is rejected
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    bus_acc(1'b0, 16'h1101, 8'h00, 8'h02, 1'b0, "glitch status");

    check("tx scoreboard drained", 32'(tx_exp.size()), 32'h0);
    check("rd scoreboard drained", 32'(rd_exp.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
